// File: rtl/kyber_ntt_pkg.sv
// kyber_ntt_pkg: shared sizes and cstate encoding for the NTT sequencer.
package kyber_ntt_pkg;
  localparam int N_COEF = 256;
  localparam int COEF_W = 16;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP0  = 3'd1,
    ST_NTT   = 3'd2,
    ST_RED   = 3'd3,
    ST_PUSH0 = 3'd4,
    ST_POP1  = 3'd5,
    ST_PUSH1 = 3'd6
  } cstate_t;

  function automatic logic is_pop(cstate_t s);
    return s == ST_POP0 || s == ST_POP1;
  endfunction

  function automatic logic is_push(cstate_t s);
    return s == ST_PUSH0 || s == ST_PUSH1;
  endfunction
endpackage

// File: rtl/ntt_push_fifo.sv
// ntt_push_fifo: 2-entry output FIFO with occupancy count for the Push pass.
module ntt_push_fifo
  import kyber_ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [COEF_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [COEF_W-1:0] head,
  output logic [1:0]        count
);
  logic [COEF_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;
  logic              pop_ok;
  logic              push_ok;

  assign valid   = cnt_q != 2'd0;
  assign pop_ok  = pop && valid;
  assign push_ok = push && (cnt_q != 2'd2 || pop_ok);
  assign head    = valid ? mem_q[rd_ptr_q] : '0;
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end
endmodule

// File: rtl/ntt_state_ctrl.sv
// ntt_state_ctrl: Pop/NTT/Reduce/Push sequencer owning the BRAM port steering.
// Optional watchdog on the engine waits: define NTT_CTRL_WATCHDOG_EN.
module ntt_state_ctrl
  import kyber_ntt_pkg::*;
#(
  parameter int N              = N_COEF,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              two_poly,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        cstate,
  output logic              ntt_start,
  input  logic              ntt_done,
  output logic              red_start,
  input  logic              red_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic              M0_WEN_Out,
  output logic [7:0]        M0_WAd_Out,
  output logic [15:0]       M0_WData_Out,
  output logic [7:0]        M0_RAd_Out,
  input  logic [15:0]       M0_RData
);
  localparam int CW = $clog2(N) + 1;

  cstate_t           st_q, st_d;
  logic [CW-1:0]     cnt_q, ocnt_q;
  logic              tp_q, pass_q, first_q;
  logic              inflight_q, done_q, wen_q;
  logic [ADDR_W-1:0] wad_q;
  logic [COEF_W-1:0] wdata_q;
  logic              acc, pop, rd_issue, timeout;
  logic              f_valid;
  logic [1:0]        f_count;
  logic [COEF_W-1:0] f_head;

`ifdef NTT_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;

  assign timeout = (st_q == ST_NTT || st_q == ST_RED) &&
                   wd_q == WD_W'(TIMEOUT_CYCLES - 1);
  assign err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (st_d != st_q) wd_q <= '0;
      else if (st_q == ST_NTT || st_q == ST_RED) wd_q <= wd_q + WD_W'(1);
      if (st_q == ST_IDLE && start) err_q <= 1'b0;
      else if (timeout && st_d == ST_IDLE) err_q <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES != 0;
  assign timeout    = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE:  if (start) st_d = ST_POP0;
      ST_POP0,
      ST_POP1:  if (cnt_q == CW'(N)) st_d = ST_NTT;
      ST_NTT: begin
        if (ntt_done)     st_d = ST_RED;
        else if (timeout) st_d = ST_IDLE;
      end
      ST_RED: begin
        if (red_done)     st_d = pass_q ? ST_PUSH1 : ST_PUSH0;
        else if (timeout) st_d = ST_IDLE;
      end
      ST_PUSH0: if (pop && ocnt_q == CW'(N - 1))
                  st_d = tp_q ? ST_POP1 : ST_IDLE;
      ST_PUSH1: if (pop && ocnt_q == CW'(N - 1))
                  st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = st_q != ST_IDLE;
    in_ready  = is_pop(st_q) && cnt_q < CW'(N);
    acc       = in_valid && in_ready;
    pop       = f_valid && out_ready;
    ntt_start = st_q == ST_NTT && first_q;
    red_start = st_q == ST_RED && first_q;
    // Count the pop of this cycle so a steady stream keeps one read in flight.
    rd_issue  = is_push(st_q) && cnt_q < CW'(N) &&
                ({1'b0, f_count} + {2'b00, inflight_q} -
                 {2'b00, pop}) < 3'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      ocnt_q     <= '0;
      tp_q       <= 1'b0;
      pass_q     <= 1'b0;
      first_q    <= 1'b0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wen_q      <= 1'b0;
      wad_q      <= '0;
      wdata_q    <= '0;
    end else begin
      first_q <= st_d != st_q;
      if (st_d != st_q) begin
        cnt_q  <= '0;
        ocnt_q <= '0;
      end else begin
        if (acc || rd_issue) cnt_q <= cnt_q + CW'(1);
        if (pop) ocnt_q <= ocnt_q + CW'(1);
      end
      if (st_q == ST_IDLE && start) begin
        tp_q   <= two_poly;
        pass_q <= 1'b0;
      end else if (st_q == ST_PUSH0 && st_d == ST_POP1) begin
        pass_q <= 1'b1;
      end
      wen_q      <= acc;
      wad_q      <= acc ? cnt_q[ADDR_W-1:0] : '0;
      wdata_q    <= acc ? in_data : '0;
      inflight_q <= rd_issue;
      done_q     <= is_push(st_q) && st_d == ST_IDLE;
    end
  end

  ntt_push_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (M0_RData),
    .pop       (out_ready),
    .valid     (f_valid),
    .head      (f_head),
    .count     (f_count)
  );

  assign cstate       = st_q;
  assign done         = done_q;
  assign out_valid    = f_valid;
  assign out_data     = f_head;
  assign M0_WEN_Out   = wen_q;
  assign M0_WAd_Out   = wad_q;
  assign M0_WData_Out = wdata_q;
  assign M0_RAd_Out   = rd_issue ? cnt_q[ADDR_W-1:0] : '0;
endmodule

// File: tb/tb_ntt_state_ctrl.sv
// tb_ntt_state_ctrl: job table plus abort, stray-input and watchdog sequences.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_ntt_state_ctrl;
  localparam int NC = 256;

  logic        clk = 1'b0;
  logic        rst, start, two_poly, ntt_done, red_done;
  logic        in_valid, out_ready;
  logic [15:0] in_data, M0_RData;
  logic        busy, done, err, ntt_start, red_start;
  logic        in_ready, out_valid, M0_WEN_Out;
  logic [2:0]  cstate;
  logic [15:0] out_data, M0_WData_Out;
  logic [7:0]  M0_WAd_Out, M0_RAd_Out;

  always #5 clk = ~clk;

  ntt_state_ctrl #(.N(NC), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .start(start), .two_poly(two_poly),
    .busy(busy), .done(done), .err(err), .cstate(cstate),
    .ntt_start(ntt_start), .ntt_done(ntt_done),
    .red_start(red_start), .red_done(red_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .M0_WEN_Out(M0_WEN_Out), .M0_WAd_Out(M0_WAd_Out),
    .M0_WData_Out(M0_WData_Out), .M0_RAd_Out(M0_RAd_Out),
    .M0_RData(M0_RData)
  );

  logic [15:0] bram [NC];
  always @(posedge clk) begin
    if (M0_WEN_Out) bram[M0_WAd_Out] <= M0_WData_Out;
    M0_RData <= bram[M0_RAd_Out];
  end

  typedef struct {
    bit tp;
    int gap;
    int bp;
    int exp_outs;
    int exp_pop;
    int exp_push;
  } job_t;

  job_t jobs [4];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, longint act, longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [15:0] val(int p, int i);
    return (p != 0) ? 16'(32'h8000 + 3 * i) : 16'(i);
  endfunction

  function automatic longint outs_vec();
    return longint'({busy, done, err, in_ready, out_valid, ntt_start,
                     red_start, M0_WEN_Out, M0_WAd_Out, M0_WData_Out,
                     M0_RAd_Out, out_data, cstate});
  endfunction

  function automatic bit pop_st(logic [2:0] s);
    return s == 3'd1 || s == 3'd5;
  endfunction

  function automatic bit push_st(logic [2:0] s);
    return s == 3'd4 || s == 3'd6;
  endfunction

  task automatic run_job(input bit tp, input int gap, input int bp,
                         input int exp_outs, input int exp_pop,
                         input int exp_push, input int abort_at,
                         input bit stray, input bit eng_on);
    logic [15:0] exp_q [$];
    int          e [$];
    logic [2:0]  st;
    logic [2:0]  prev_st = 3'd0;
    longint      seq_act = 0, seq_exp = 0;
    int seq_len = 0, passes, cyc;
    int outs = 0, data_bad = 0, done_n = 0, ns_n = 0, rs_n = 0;
    int ntt_cyc = 0, pop_cyc = 0, push_cyc = 0;
    int wr_err = 0, wr_tot = 0, wr_n = 0, wr_pass = 0;
    int wen_bad = 0, ir_bad = 0, lat_bad = 0, max_out = 0;
    int rd_n = 0, pout = 0, push_ent = 0, in_pass = 0, in_idx = 0;
    int ntt_t = -1, red_t = -1, stray_t = -1, stray_pend = 0;
    int ns_cyc = -1, idle_cyc = -1, idle_n = 0;
    bit first_seen = 0, aborted = 0;

    passes = tp ? 2 : 1;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < NC; i++) exp_q.push_back(val(p, i));

    for (cyc = 0; cyc < 8000; cyc++) begin
      @(posedge clk); #1;
      start     = (cyc == 0);
      two_poly  = (cyc == 0) ? tp : 1'($urandom_range(1));
      in_valid  = $urandom_range(99) >= gap;
      in_data   = in_valid ? val(in_pass, in_idx) : 16'($urandom);
      out_ready = $urandom_range(99) >= bp;
      ntt_done  = eng_on && ntt_t == 0;
      red_done  = eng_on && red_t == 0;
      if (ntt_t >= 0) ntt_t--;
      if (red_t >= 0) red_t--;
      if (stray_t == 0) begin
        start      = 1'b1;
        red_done   = 1'b1;
        stray_pend = 2;
      end
      if (stray_t >= 0) stray_t--;
      if (abort_at >= 0 && prev_st == 3'd4 && pout == abort_at) begin
        rst     = 1'b1;
        aborted = 1'b1;
      end
      @(negedge clk);
      if (aborted) break;
      st = cstate;
      if (st != prev_st) begin
        seq_act = (seq_act << 3) | longint'(st);
        seq_len++;
        if (push_st(st)) begin
          push_ent   = cyc;
          rd_n       = 0;
          pout       = 0;
          first_seen = 0;
        end
        prev_st = st;
      end
      if (stray_pend > 0) begin
        stray_pend--;
        if (stray_pend == 0) chk("stray_hold_ntt", longint'(st), 2);
      end
      if (ntt_start) begin
        ns_n++;
        ntt_t  = 9;
        ns_cyc = cyc;
        if (stray && ns_n == 1) stray_t = 3;
      end
      if (red_start) begin
        rs_n++;
        red_t = 9;
      end
      if (pop_st(st)) pop_cyc++;
      if (push_st(st)) push_cyc++;
      if (st == 3'd2) ntt_cyc++;
      if (in_ready && !pop_st(st)) ir_bad++;
      if (in_valid && in_ready) begin
        in_idx++;
        if (in_idx == NC) begin
          in_idx = 0;
          in_pass++;
        end
      end
      if (M0_WEN_Out) begin
        if (!pop_st(st)) wen_bad++;
        if (M0_WAd_Out !== wr_n[7:0] ||
            M0_WData_Out !== val(wr_pass, wr_n)) wr_err++;
        wr_tot++;
        wr_n++;
        if (wr_n == NC) begin
          wr_n = 0;
          wr_pass++;
        end
      end
      if (push_st(st)) begin
        if (rd_n - pout > max_out) max_out = rd_n - pout;
        if (rd_n < NC && M0_RAd_Out == rd_n[7:0]) rd_n++;
      end
      if (out_valid && !first_seen) begin
        first_seen = 1;
        if (cyc - push_ent != 2) lat_bad++;
      end
      if (out_valid && out_ready) begin
        if (outs >= exp_q.size() || out_data !== exp_q[outs]) data_bad++;
        outs++;
        pout++;
      end
      if (done) done_n++;
      if (st == 3'd0 && cyc > 0) begin
        if (idle_cyc < 0) idle_cyc = cyc;
        idle_n++;
        if (idle_n == 4) break;
      end
    end

    if (aborted) begin
      @(posedge clk); #1;
      rst       = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      ntt_done  = 1'b0;
      red_done  = 1'b0;
      @(negedge clk);
      chk("abort_outputs_reset", outs_vec(), 0);
      chk("abort_cstate", longint'(cstate), 0);
      repeat (3) begin
        @(negedge clk);
        if (done) done_n++;
      end
      chk("abort_no_done", done_n, 0);
      return;
    end

    chk("job_finished", longint'(cyc >= 8000), 0);
    seq_act = seq_act | (longint'(seq_len) << 40);

    if (!eng_on) begin
      chk("wd_latency", idle_cyc - ns_cyc, 50);
      chk("wd_err_set", longint'(err), 1);
      chk("wd_no_done", done_n, 0);
      e = '{1, 2, 0};
      foreach (e[i]) seq_exp = (seq_exp << 3) | longint'(e[i]);
      chk("wd_state_seq", seq_act, seq_exp | (longint'(e.size()) << 40));
      return;
    end

    if (tp) e = '{1, 2, 3, 4, 5, 2, 3, 6, 0};
    else    e = '{1, 2, 3, 4, 0};
    foreach (e[i]) seq_exp = (seq_exp << 3) | longint'(e[i]);
    seq_exp = seq_exp | (longint'(e.size()) << 40);

    chk("out_count", outs, exp_outs);
    chk("out_data_bad", data_bad, 0);
    chk("done_pulses", done_n, 1);
    chk("ntt_start_pulses", ns_n, passes);
    chk("red_start_pulses", rs_n, passes);
    chk("ntt_cycles", ntt_cyc, 11 * passes);
    chk("state_seq", seq_act, seq_exp);
    chk("max_outstanding_le2", longint'(max_out <= 2), 1);
    chk("bram_write_bad", wr_err, 0);
    chk("bram_write_count", wr_tot, NC * passes);
    chk("wen_outside_pop", wen_bad, 0);
    chk("in_ready_outside_pop", ir_bad, 0);
    chk("push_first_valid_lat", lat_bad, 0);
    chk("err_low", longint'(err), 0);
    if (exp_pop > 0) chk("pop_cycles", pop_cyc, exp_pop);
    if (exp_push > 0) chk("push_cycles", push_cyc, exp_push);
  endtask

  initial begin
    jobs[0] = '{1'b0, 0, 0, 256, 257, 258};
    jobs[1] = '{1'b1, 0, 0, 512, 514, 516};
    jobs[2] = '{1'b0, 50, 50, 256, 0, 0};
    jobs[3] = '{1'b1, 30, 50, 512, 0, 0};

    rst       = 1'b1;
    start     = 1'b0;
    two_poly  = 1'b0;
    ntt_done  = 1'b0;
    red_done  = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs_vec(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", outs_vec(), 0);

    foreach (jobs[j])
      run_job(jobs[j].tp, jobs[j].gap, jobs[j].bp, jobs[j].exp_outs,
              jobs[j].exp_pop, jobs[j].exp_push, -1, 1'b0, 1'b1);

    run_job(1'b0, 0, 0, 256, 0, 0, 100, 1'b0, 1'b1);
    run_job(1'b0, 0, 0, 256, 257, 258, -1, 1'b0, 1'b1);
    run_job(1'b0, 0, 30, 256, 257, 0, -1, 1'b1, 1'b1);

`ifdef NTT_CTRL_WATCHDOG_EN
    run_job(1'b0, 0, 0, 0, 0, 0, -1, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("wd_err_cleared", longint'(err), 0);
    chk("wd_restart_pop0", longint'(cstate), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
